multi_clock_divider: RTL and testbench

Parametrised, multi-channel successor to the fixed power-of-two clock divider. Each of NUM_CH channels divides the system clock by a runtime-programmable ratio (div+1) and produces a one-cycle enable pulse plus a 50%-duty square output. Divisor updates are shadowed and applied only at a period boundary, so outputs never glitch. A global sync input realigns all channels. The block sits beside the system clock and feeds enable strobes to peripherals such as UART baud generators, LED blinkers and sampling logic.

---
 rtl/multi_clock_divider.sv | 88 ++++++++
 tb/tb_multi_clock_divider.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider: each channel emits a one-cycle enable
// strobe every (div+1) cycles plus a 50%-duty square wave, with glitch-free divisor updates.
module multi_clock_divider #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]  cfg_div,
    input  logic              cfg_en,
    input  logic              sync,
    output logic [NUM_CH-1:0] enable_pulse,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] cfg_pending
);

    localparam logic [WIDTH-1:0] DIV_RESET = '1;

    // Out-of-range channel selects (possible when NUM_CH is not a power of two) are dropped.
    logic cfg_ch_ok;
    assign cfg_ch_ok = (int'(cfg_ch) < NUM_CH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH-1:0] count;
        logic [WIDTH-1:0] active_div;
        logic [WIDTH-1:0] shadow_div;
        logic             en;
        logic             pending;
        logic             sq;
        logic             wr_hit;
        logic             terminal;

        assign wr_hit   = cfg_wr & cfg_ch_ok & (int'(cfg_ch) == i);
        assign terminal = en & (count == active_div);

        always_ff @(posedge clk) begin
            if (reset) begin
                count      <= '0;
                active_div <= DIV_RESET;
                shadow_div <= DIV_RESET;
                en         <= 1'b1;
                pending    <= 1'b0;
                sq         <= 1'b0;
            end else if (wr_hit && !cfg_en) begin
                en         <= 1'b0;
                count      <= '0;
                sq         <= 1'b0;
                pending    <= 1'b0;
                active_div <= cfg_div;
                shadow_div <= cfg_div;
            end else if (wr_hit && !en) begin
                en         <= 1'b1;
                count      <= '0;
                pending    <= 1'b0;
                active_div <= cfg_div;
                shadow_div <= cfg_div;
            end else if (en) begin
                if (sync || terminal) begin
                    // Period boundary: the only point where a new divisor may take effect.
                    count <= '0;
                    sq    <= sync ? 1'b0 : ~sq;
                    if (wr_hit) begin
                        active_div <= cfg_div;
                        shadow_div <= cfg_div;
                        pending    <= 1'b0;
                    end else if (pending) begin
                        active_div <= shadow_div;
                        pending    <= 1'b0;
                    end
                end else begin
                    count <= count + WIDTH'(1);
                    if (wr_hit) begin
                        shadow_div <= cfg_div;
                        pending    <= 1'b1;
                    end
                end
            end
        end

        assign enable_pulse[i] = terminal;
        assign clk_out[i]      = sq;
        assign cfg_pending[i]  = pending;
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Scoreboard bench for multi_clock_divider (NUM_CH=5, WIDTH=4) driven by directed writes.
module tb_multi_clock_divider;

    localparam int NUM_CH = 5;
    localparam int WIDTH  = 4;
    localparam int CH_W   = 3;
    localparam int R      = 3;   // cycle index where count=0 right after reset

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_wr = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [WIDTH-1:0]  cfg_div = '0;
    logic              cfg_en = 1'b0;
    logic              sync = 1'b0;
    logic [NUM_CH-1:0] enable_pulse;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] cfg_pending;

    multi_clock_divider #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_en(cfg_en), .sync(sync), .enable_pulse(enable_pulse), .clk_out(clk_out),
        .cfg_pending(cfg_pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          sig;   // 0 enable_pulse, 1 clk_out, 2 cfg_pending
        logic [4:0]  mask;
        logic [4:0]  val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic push(input int c, input int s, input logic [4:0] m, input logic [4:0] v,
                        input string n);
        exp_t e;
        int   idx;
        e.cyc = c; e.sig = s; e.mask = m; e.val = v; e.name = n;
        idx = sb.size();
        while (idx > 0 && sb[idx-1].cyc > c) idx--;
        sb.insert(idx, e);
    endtask

    // Monitor: compares every expectation due in the current cycle.
    exp_t       me;
    logic [4:0] act;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            me = sb.pop_front();
            case (me.sig)
                0:       act = enable_pulse;
                1:       act = clk_out;
                default: act = cfg_pending;
            endcase
            n_checks++;
            if (me.cyc != cyc || (act & me.mask) != (me.val & me.mask)) begin
                n_fails++;
                $display("FAIL %s cyc=%0d (due %0d) got=%b want=%b mask=%b",
                         me.name, cyc, me.cyc, act & me.mask, me.val & me.mask, me.mask);
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
        #1;
    endtask

    task automatic do_write(input int t, input int ch, input int div, input logic en);
        wait_cyc(t);
        cfg_wr  = 1'b1;
        cfg_ch  = CH_W'(ch);
        cfg_div = WIDTH'(div);
        cfg_en  = en;
        wait_cyc(t + 1);
        cfg_wr  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset defaults: every channel divides by 16.
        push(R,      0, 5'h1F, 5'h00, "rst_pulse");
        push(R,      1, 5'h1F, 5'h00, "rst_clkout");
        push(R,      2, 5'h1F, 5'h00, "rst_pending");
        push(R+14,   0, 5'h1F, 5'h00, "pre_first_pulse");
        push(R+15,   0, 5'h1F, 5'h1F, "first_pulse");
        push(R+16,   0, 5'h1F, 5'h00, "pulse_one_cycle");
        push(R+16,   1, 5'h1F, 5'h1F, "clkout_rise");
        push(R+31,   0, 5'h1F, 5'h1F, "second_pulse");
        push(R+31,   1, 5'h1F, 5'h1F, "clkout_high");
        push(R+32,   1, 5'h1F, 5'h00, "clkout_fall");
        wait_cyc(R);
        reset = 1'b0;

        // Shadowed write to ch1 at count 3.
        push(R+36, 2, 5'h02, 5'h02, "ch1_pending_set");
        push(R+47, 2, 5'h02, 5'h02, "ch1_pending_hold");
        push(R+48, 2, 5'h02, 5'h00, "ch1_pending_clr");
        push(R+47, 0, 5'h1F, 5'h1F, "old_period_pulse");
        push(R+51, 0, 5'h02, 5'h00, "ch1_no_early");
        push(R+52, 0, 5'h1F, 5'h02, "ch1_new_pulse1");
        push(R+53, 1, 5'h02, 5'h00, "ch1_clkout_low");
        push(R+57, 0, 5'h1F, 5'h02, "ch1_new_pulse2");
        push(R+58, 1, 5'h02, 5'h02, "ch1_clkout_high");
        push(R+62, 0, 5'h1F, 5'h02, "ch1_new_pulse3");
        push(R+63, 0, 5'h1F, 5'h1D, "others_unchanged");
        do_write(R+35, 1, 4, 1'b1);

        // ch2 div=0 written in its terminal cycle, then disabled.
        for (int k = 0; k < 6; k++) begin
            push(R+64+k, 0, 5'h04, 5'h04, "ch2_div0_pulse");
            push(R+64+k, 1, 5'h04, (k % 2 == 1) ? 5'h04 : 5'h00, "ch2_div0_toggle");
        end
        push(R+64, 2, 5'h04, 5'h00, "ch2_no_pending");
        for (int k = 0; k < 5; k++) begin
            push(R+71+k, 0, 5'h04, 5'h00, "ch2_off_pulse");
            push(R+71+k, 1, 5'h04, 5'h00, "ch2_off_clkout");
        end
        do_write(R+63, 2, 0, 1'b1);
        do_write(R+70, 2, 0, 1'b0);

        // ch0 div=9, ch3 div=6 left pending, then applied by sync.
        push(R+73, 2, 5'h01, 5'h01, "ch0_pending");
        push(R+76, 2, 5'h09, 5'h09, "ch03_pending");
        push(R+77, 2, 5'h09, 5'h00, "sync_clr_pending");
        push(R+77, 1, 5'h1F, 5'h00, "sync_clkout_zero");
        push(R+77, 0, 5'h1F, 5'h00, "sync_no_pulse");
        push(R+82, 0, 5'h09, 5'h00, "sync_ch3_early");
        push(R+83, 0, 5'h1F, 5'h08, "sync_ch3_pulse");
        push(R+84, 1, 5'h09, 5'h08, "sync_ch3_clkout");
        push(R+86, 0, 5'h1F, 5'h03, "sync_ch0_pulse");
        do_write(R+72, 0, 9, 1'b1);
        do_write(R+73, 3, 6, 1'b1);
        wait_cyc(R+76);
        sync = 1'b1;
        wait_cyc(R+77);
        sync = 1'b0;

        // Write ch0 div=2 during its terminal cycle: applied directly.
        push(R+97,  2, 5'h01, 5'h00, "direct_no_pending");
        push(R+98,  2, 5'h01, 5'h00, "direct_no_pending2");
        push(R+98,  0, 5'h01, 5'h00, "direct_no_early");
        push(R+99,  0, 5'h01, 5'h01, "direct_pulse1");
        push(R+101, 0, 5'h01, 5'h00, "direct_gap");
        push(R+102, 0, 5'h01, 5'h01, "direct_pulse2");
        do_write(R+96, 0, 2, 1'b1);

        // Out-of-range channel ignored; reset mid-period with a pending write.
        push(R+104, 2, 5'h1F, 5'h00, "badch_no_pending");
        push(R+106, 0, 5'h02, 5'h02, "badch_ch1_alive");
        push(R+106, 2, 5'h08, 5'h08, "ch3_pending_pre_rst");
        push(R+108, 0, 5'h1F, 5'h00, "rst2_pulse");
        push(R+108, 1, 5'h1F, 5'h00, "rst2_clkout");
        push(R+108, 2, 5'h1F, 5'h00, "rst2_pending");
        push(R+109, 0, 5'h1F, 5'h00, "rst2_no_pulse");
        push(R+122, 0, 5'h1F, 5'h00, "rst2_pre_pulse");
        push(R+123, 0, 5'h1F, 5'h1F, "rst2_pulse_div15");
        push(R+124, 1, 5'h1F, 5'h1F, "rst2_clkout_rise");
        do_write(R+103, 5, 3, 1'b0);
        do_write(R+105, 3, 1, 1'b1);
        wait_cyc(R+107);
        reset = 1'b1;
        wait_cyc(R+108);
        reset = 1'b0;

        wait_cyc(R+130);
        n_checks++;
        if (enable_pulse !== 5'h00) begin
            n_fails++;
            $display("FAIL final_pulse cyc=%0d got=%b want=%b", cyc, enable_pulse, 5'h00);
        end
        n_checks++;
        if (clk_out !== 5'h1F) begin
            n_fails++;
            $display("FAIL final_clkout cyc=%0d got=%b want=%b", cyc, clk_out, 5'h1F);
        end
        n_checks++;
        if (cfg_pending !== 5'h00) begin
            n_fails++;
            $display("FAIL final_pending cyc=%0d got=%b want=%b", cyc, cfg_pending, 5'h00);
        end
        while (sb.size() > 0) begin
            me = sb.pop_front();
            n_checks++;
            n_fails++;
            $display("FAIL %s never_checked due=%0d got=none want=%b", me.name, me.cyc, me.val);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
